// File: rtl/snes_video_pkg.sv
// snes_video_pkg: shared pixel types and constants for the video output path
package snes_video_pkg;
  localparam int CHAN_W = 5;
  localparam int DEPTH_DEF = 4;
  localparam int PH_256H = 1;
  localparam int PH_512H = 0;
  typedef struct packed {
    logic [CHAN_W-1:0] b;
    logic [CHAN_W-1:0] g;
    logic [CHAN_W-1:0] r;
  } bgr555_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small synchronous FIFO with a DEPTH+1-state occupancy counter
module pixel_fifo import snes_video_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W = 15
) (
  input  logic         mclock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign rdata = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge mclock)
    if (do_push) mem[wp] <= wdata;
  always_ff @(posedge mclock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dac_pixel_out.sv
// dac_pixel_out: FIFO-buffered BGR555 pixel output to the video DAC at the 256h/512h rate.
// Optional DAC_BRIGHTNESS_EN scales each channel by (brightness+1)/16.
module dac_pixel_out import snes_video_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = 16
) (
  input  logic              mclock,
  input  logic              reset,
  input  logic [1:0]        phase,
  input  logic              hires,
  input  logic              pix_valid,
  input  logic [14:0]       pix_data,
  output logic              pix_ready,
  input  logic              blank,
  input  logic [3:0]        brightness,
  output logic [CHAN_W-1:0] dac_r,
  output logic [CHAN_W-1:0] dac_g,
  output logic [CHAN_W-1:0] dac_b,
  output logic              dac_blank,
  output logic              dac_latch,
  output logic [CNT_W-1:0]  underflow_cnt
);
  bgr555_t head;
  logic full, empty, strobe, push, pop;
  logic [CHAN_W-1:0] sr, sg, sb;
`ifdef DAC_BRIGHTNESS_EN
  function automatic logic [CHAN_W-1:0] scale(input logic [CHAN_W-1:0] c, input logic [3:0] br);
    logic [9:0] p;
    p = 10'(c) * (10'(br) + 10'd1);
    return p[8:4];
  endfunction
  assign sr = scale(head.r, brightness);
  assign sg = scale(head.g, brightness);
  assign sb = scale(head.b, brightness);
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign sr = head.r;
  assign sg = head.g;
  assign sb = head.b;
`endif
  assign strobe = hires ? phase[PH_512H] : (phase[PH_256H] && phase[PH_512H]);
  assign pix_ready = !full && !reset;
  assign push = pix_valid && pix_ready;
  assign pop = strobe && !blank && !empty;
  pixel_fifo #(.DEPTH(DEPTH), .W(15)) u_fifo (
    .mclock(mclock),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wdata(pix_data),
    .rdata(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge mclock) begin
    if (reset) begin
      dac_r <= '0;
      dac_g <= '0;
      dac_b <= '0;
      dac_blank <= 1'b1;
      dac_latch <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      dac_latch <= strobe;
      if (strobe) begin
        dac_blank <= blank;
        if (blank) begin
          dac_r <= '0;
          dac_g <= '0;
          dac_b <= '0;
        end else if (!empty) begin
          dac_r <= sr;
          dac_g <= sg;
          dac_b <= sb;
        end else if (!(&underflow_cnt)) begin
          underflow_cnt <= underflow_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dac_pixel_out.sv
// tb_dac_pixel_out: queue-based reference model checked every cycle, plus directed literal checks
module tb_dac_pixel_out;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;
  logic mclock, reset, hires, pix_valid, pix_ready, blank, dac_blank, dac_latch;
  logic [1:0] phase;
  logic [14:0] pix_data;
  logic [3:0] brightness;
  logic [4:0] dac_r, dac_g, dac_b;
  logic [CNT_W-1:0] underflow_cnt;
  int checks = 0;
  int errors = 0;
  logic [14:0] q[$];
  int m_r = 0, m_g = 0, m_b = 0, m_blank = 1, m_latch = 0, m_cnt = 0;
  dac_pixel_out #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .mclock(mclock), .reset(reset), .phase(phase), .hires(hires),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .blank(blank), .brightness(brightness),
    .dac_r(dac_r), .dac_g(dac_g), .dac_b(dac_b),
    .dac_blank(dac_blank), .dac_latch(dac_latch), .underflow_cnt(underflow_cnt)
  );
  initial begin
    mclock = 0;
    forever #5 mclock = ~mclock;
  end
  initial begin
    phase = 0;
    forever begin
      @(posedge mclock);
      #1 phase = 2'(phase + 1);
    end
  end
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  function automatic int sc(input int c, input int br);
`ifdef DAC_BRIGHTNESS_EN
    return (c * (br + 1)) / 16;
`else
    return c;
`endif
  endfunction
  always @(negedge mclock) begin
    bit st, rdy;
    logic [14:0] w;
    chk("pix_ready", pix_ready, (!reset && q.size() < DEPTH) ? 1 : 0);
    chk("dac_r", dac_r, m_r);
    chk("dac_g", dac_g, m_g);
    chk("dac_b", dac_b, m_b);
    chk("dac_blank", dac_blank, m_blank);
    chk("dac_latch", dac_latch, m_latch);
    chk("underflow_cnt", underflow_cnt, m_cnt);
    if (reset) begin
      q.delete();
      m_r = 0; m_g = 0; m_b = 0; m_blank = 1; m_latch = 0; m_cnt = 0;
    end else begin
      rdy = q.size() < DEPTH;
      st = hires ? phase[0] : (phase == 2'b11);
      m_latch = st;
      if (st) begin
        m_blank = blank;
        if (blank) begin
          m_r = 0; m_g = 0; m_b = 0;
        end else if (q.size() > 0) begin
          w = q.pop_front();
          m_r = sc(w[4:0], brightness);
          m_g = sc(w[9:5], brightness);
          m_b = sc(w[14:10], brightness);
        end else if (m_cnt < CNT_MAX) begin
          m_cnt++;
        end
      end
      if (pix_valid && rdy) q.push_back(pix_data);
    end
  end
  task automatic step();
    @(posedge mclock);
    #1;
  endtask
  task automatic push(input logic [14:0] w);
    pix_valid = 1;
    pix_data = w;
    step();
    pix_valid = 0;
  endtask
  task automatic wait_latch(output int n);
    n = 0;
    do begin
      @(negedge mclock);
      n++;
    end while (!dac_latch && n < 20);
    chk("latch_seen", dac_latch, 1);
  endtask
  task automatic rgb(input string n, input int r, input int g, input int b);
    chk({n, "_r"}, dac_r, r);
    chk({n, "_g"}, dac_g, g);
    chk({n, "_b"}, dac_b, b);
  endtask
  initial begin
    int n, saved;
    reset = 1; pix_valid = 0; pix_data = 0; blank = 1; hires = 0; brightness = 15;
    repeat (3) step();
    @(negedge mclock);
    chk("rst_blank", dac_blank, 1);
    chk("rst_ready", pix_ready, 0);
    chk("rst_cnt", underflow_cnt, 0);
    chk("rst_latch", dac_latch, 0);
    step();
    reset = 0;
    push(15'h7FFF);
    push(15'h001F);
    blank = 0;
    @(negedge mclock);
    wait_latch(n);
    rgb("lores_w0", 31, 31, 31);
    chk("lores_blank", dac_blank, 0);
    wait_latch(n);
    rgb("lores_w1", 31, 0, 0);
    chk("lores_period", n, 4);
    step();
    blank = 1;
    hires = 1;
    saved = m_cnt;
    step();
    push(15'h0421);
    push(15'h0842);
    wait_latch(n);
    chk("blank_dac", dac_blank, 1);
    rgb("blank", 0, 0, 0);
    wait_latch(n);
    chk("blank_occ", q.size(), 2);
    chk("blank_cnt", underflow_cnt, saved);
    step();
    push(15'h1CE7);
    push(15'h7FE0);
    @(negedge mclock);
    chk("full_ready", pix_ready, 0);
    step();
    blank = 0;
    @(negedge mclock);
    wait_latch(n);
    rgb("hires_w0", 1, 1, 1);
    chk("ready_after_pop", pix_ready, 1);
    wait_latch(n);
    rgb("hires_w1", 2, 2, 2);
    chk("hires_period", n, 2);
    wait_latch(n);
    rgb("hires_w2", 7, 7, 7);
    wait_latch(n);
    rgb("hires_w3", 0, 31, 31);
    step();
    blank = 1;
    push(15'h1111);
    push(15'h2222);
    push(15'h3333);
    reset = 1;
    step();
    @(negedge mclock);
    chk("mid_rst_blank", dac_blank, 1);
    chk("mid_rst_r", dac_r, 0);
    chk("mid_rst_latch", dac_latch, 0);
    chk("mid_rst_cnt", underflow_cnt, 0);
    chk("mid_rst_ready", pix_ready, 0);
    step();
    reset = 0; blank = 0; hires = 0;
    @(negedge mclock);
    wait_latch(n);
    chk("post_rst_uf", underflow_cnt, 1);
    chk("post_rst_blank", dac_blank, 0);
    step();
    blank = 1;
    push(15'h03E0);
    blank = 0;
    @(negedge mclock);
    wait_latch(n);
    rgb("green", 0, 31, 0);
    chk("green_cnt", underflow_cnt, 1);
    repeat (3) wait_latch(n);
    rgb("green_hold", 0, 31, 0);
    chk("uf_three", underflow_cnt, 4);
    step();
    hires = 1;
    repeat (15) wait_latch(n);
    chk("uf_sat", underflow_cnt, CNT_MAX);
    chk("sat_hold_g", dac_g, 31);
    step();
    blank = 1;
    push(15'h001F);
    brightness = 7;
    blank = 0;
    @(negedge mclock);
    wait_latch(n);
`ifdef DAC_BRIGHTNESS_EN
    chk("bright7", dac_r, 15);
`else
    chk("bright7", dac_r, 31);
`endif
    step();
    blank = 1;
    push(15'h001F);
    brightness = 0;
    blank = 0;
    @(negedge mclock);
    wait_latch(n);
`ifdef DAC_BRIGHTNESS_EN
    chk("bright0", dac_r, 1);
`else
    chk("bright0", dac_r, 31);
`endif
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
